// File: rtl/mem_access_stage.sv
// MEM stage + MEM/WB register: drives a req/gnt/rvalid data port, aligns load data, registers write-back.
// Latency: non-load result reaches WB 1 cycle after presentation; load data 1 cycle after rvalid.
// Backpressure: mem_stall holds upstream until the access is granted (store) or its data returns (load).
module mem_access_stage #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      alu_out_mem,
    input  logic [XLEN-1:0]      store_data_mem,
    input  logic [REGADDR_W-1:0] rd_addr_mem,
    input  logic                 wb_en_mem,
    input  logic                 mem_rd_mem,
    input  logic                 mem_wr_mem,
    input  logic [2:0]           funct3_mem,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 mem_stall,
    output logic                 misalign_err,
    output logic [XLEN-1:0]      fw_from_mem,
    output logic [REGADDR_W-1:0] rd_addr_wb,
    output logic                 wb_en_wb,
    output logic [XLEN-1:0]      wb_data_wb
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GNT  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      off;
    logic            is_mem;
    logic            f3_legal;
    logic            aligned;
    logic            illegal;
    logic            retire;
    logic            load_ok;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_val;

    assign off     = alu_out_mem[1:0];
    assign is_mem  = mem_rd_mem | mem_wr_mem;
    assign illegal = is_mem & ~(f3_legal & aligned);
    assign load_ok = mem_rd_mem & ~illegal;

    always_comb begin
        f3_legal = 1'b0;
        case (funct3_mem)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default: f3_legal = 1'b0;
        endcase
        aligned = 1'b1;
        case (funct3_mem[1:0])
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // The request stays up in WAIT_GNT because stall freezes the inputs that formed it.
    assign dmem_req     = ((state == IDLE) & is_mem & ~illegal) | (state == WAIT_GNT);
    assign dmem_we      = dmem_req & mem_wr_mem;
    assign dmem_addr    = {alu_out_mem[XLEN-1:2], 2'b00};
    assign misalign_err = (state == IDLE) & illegal;
    assign fw_from_mem  = alu_out_mem;
    assign mem_stall    = ~retire;

    always_comb begin
        case (funct3_mem[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << off;
                dmem_wdata = {4{store_data_mem[7:0]}};
            end
            2'b01: begin
                dmem_be    = off[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{store_data_mem[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = store_data_mem;
            end
        endcase
    end

    always_comb begin
        case (off)
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_mem)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        case (state)
            IDLE:      retire = ~is_mem | illegal | (dmem_gnt & mem_wr_mem);
            WAIT_GNT:  retire = dmem_gnt & mem_wr_mem;
            WAIT_DATA: retire = dmem_rvalid;
            default:   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_addr_wb <= '0;
            wb_en_wb   <= 1'b0;
            wb_data_wb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem && !illegal) begin
                        if (!dmem_gnt)
                            state <= WAIT_GNT;
                        else if (mem_rd_mem)
                            state <= WAIT_DATA;
                    end
                end
                WAIT_GNT: begin
                    if (dmem_gnt)
                        state <= mem_rd_mem ? WAIT_DATA : IDLE;
                end
                WAIT_DATA: begin
                    if (dmem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (retire) begin
                rd_addr_wb <= rd_addr_mem;
                wb_en_wb   <= wb_en_mem & (rd_addr_mem != '0) & ~illegal;
                wb_data_wb <= load_ok ? load_val : alu_out_mem;
            end else begin
                wb_en_wb   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized instruction stream against a transaction-level model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out_mem, store_data_mem;
    logic [4:0]  rd_addr_mem;
    logic        wb_en_mem, mem_rd_mem, mem_wr_mem;
    logic [2:0]  funct3_mem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        mem_stall, misalign_err;
    logic [31:0] fw_from_mem;
    logic [4:0]  rd_addr_wb;
    logic        wb_en_wb;
    logic [31:0] wb_data_wb;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .alu_out_mem(alu_out_mem), .store_data_mem(store_data_mem),
        .rd_addr_mem(rd_addr_mem), .wb_en_mem(wb_en_mem),
        .mem_rd_mem(mem_rd_mem), .mem_wr_mem(mem_wr_mem), .funct3_mem(funct3_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .misalign_err(misalign_err), .fw_from_mem(fw_from_mem),
        .rd_addr_wb(rd_addr_wb), .wb_en_wb(wb_en_wb), .wb_data_wb(wb_data_wb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // per-cycle expectations and model write-back register
    logic        chk_en = 1'b0;
    logic        exp_req, exp_we, exp_stall, exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_addr;
    logic [4:0]  m_rd;
    logic        m_en;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic bit f3_ok(input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
    endfunction

    function automatic bit is_aligned(input logic [2:0] f, input logic [31:0] a);
        int size = 1 << f[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
        int unsigned sh = rd >> (8 * (a % 4));
        int unsigned b = sh % 256;
        int unsigned h = (rd >> (16 * ((a / 2) % 2))) % 65536;
        case (f)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", dmem_req, exp_req);
            chk("stall", mem_stall, exp_stall);
            chk("misalign_err", misalign_err, exp_err);
            chk("fw_from_mem", fw_from_mem, alu_out_mem);
            if (exp_req) begin
                chk("we", dmem_we, exp_we);
                chk("addr", dmem_addr, exp_addr);
                chk("be", dmem_be, exp_be);
                chk("wdata", dmem_wdata, exp_wdata);
            end
            chk("rd_addr_wb", rd_addr_wb, m_rd);
            chk("wb_en_wb", wb_en_wb, m_en);
            chk("wb_data_wb", wb_data_wb, m_data);
        end
    end

    // kind: 0 non-mem, 1 load, 2 store. g = gnt wait cycles, r = cycles from gnt to rvalid (>=1).
    task automatic run_instr(input int kind, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] d, input logic [4:0] rd, input logic wen,
                             input int g, input int r, input logic [31:0] rdata);
        bit mem   = (kind != 0);
        bit legal = f3_ok(f) && is_aligned(f, a);
        bit valid = mem && legal;
        int n     = !valid ? 1 : (kind == 2 ? g + 1 : g + r + 1);
        int size  = 1 << f[1:0];
        alu_out_mem    = a;
        store_data_mem = d;
        rd_addr_mem    = rd;
        wb_en_mem      = wen;
        mem_rd_mem     = (kind == 1);
        mem_wr_mem     = (kind == 2);
        funct3_mem     = f;
        dmem_rdata     = rdata;
        exp_addr       = a - (a % 4);
        exp_we         = (kind == 2);
        exp_err        = mem && !legal;
        if (size == 1) begin
            exp_be    = 4'(1 << (a % 4));
            exp_wdata = (d % 256) * 32'h01010101;
        end else if (size == 2) begin
            exp_be    = ((a % 4) >= 2) ? 4'hC : 4'h3;
            exp_wdata = (d % 65536) * 32'h00010001;
        end else begin
            exp_be    = 4'hF;
            exp_wdata = d;
        end
        for (int c = 0; c < n; c++) begin
            dmem_gnt = valid && (c == g);
            if (valid && kind == 1 && c > g)
                dmem_rvalid = (c == g + r);
            else if (valid && c == g)
                dmem_rvalid = 1'b0;
            else
                dmem_rvalid = 1'($urandom_range(0, 1));
            exp_req   = valid && (c <= g);
            exp_stall = (c != n - 1);
            exp_err   = mem && !legal;
            @(posedge clk);
            if (c == n - 1) begin
                m_rd   = rd;
                m_en   = wen && (rd != 0) && legal;
                m_data = (valid && kind == 1) ? extract(f, a, rdata) : a;
            end else begin
                m_en = 1'b0;
            end
            #1;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    task automatic set_nop();
        alu_out_mem = 0; store_data_mem = 0; rd_addr_mem = 0; wb_en_mem = 0;
        mem_rd_mem = 0; mem_wr_mem = 0; funct3_mem = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    initial begin
        logic [2:0] lf [5];
        lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;
        set_nop();
        exp_req = 0; exp_we = 0; exp_stall = 0; exp_err = 0; exp_be = 0; exp_wdata = 0; exp_addr = 0;
        m_rd = 0; m_en = 0; m_data = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rd_addr_wb", rd_addr_wb, 0);
        chk("reset wb_en_wb", wb_en_wb, 0);
        chk("reset wb_data_wb", wb_data_wb, 0);
        chk("reset misalign_err", misalign_err, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // SW aligned, granted immediately
        run_instr(2, 3'd2, 32'h104, 32'hDEADBEEF, 5'd0, 1'b0, 0, 1, 0);
        chk("sw wb_en", wb_en_wb, 0);

        // SB at byte 3, then SH upper half, with literal lane checks
        alu_out_mem = 32'h103; store_data_mem = 32'hAB; mem_wr_mem = 1; funct3_mem = 3'd0;
        #1;
        chk("sb be", dmem_be, 4'b1000);
        chk("sb wdata", dmem_wdata, 32'hABABABAB);
        run_instr(2, 3'd0, 32'h103, 32'hAB, 5'd0, 1'b0, 1, 1, 0);
        alu_out_mem = 32'h102; funct3_mem = 3'd1;
        #1;
        chk("sh be", dmem_be, 4'b1100);
        run_instr(2, 3'd1, 32'h102, 32'h1234, 5'd0, 1'b0, 0, 1, 0);

        // LH/LHU upper half, gnt after 2 waits, rvalid 3 cycles later
        run_instr(1, 3'd1, 32'h102, 0, 5'd7, 1'b1, 2, 3, 32'h80FF1234);
        chk("lh data", wb_data_wb, 32'hFFFF80FF);
        chk("lh en", wb_en_wb, 1);
        run_instr(1, 3'd5, 32'h102, 0, 5'd7, 1'b1, 2, 3, 32'h80FF1234);
        chk("lhu data", wb_data_wb, 32'h000080FF);

        // misaligned LW and illegal funct3
        run_instr(1, 3'd2, 32'h106, 0, 5'd8, 1'b1, 0, 1, 0);
        chk("lw misalign en", wb_en_wb, 0);
        run_instr(1, 3'd3, 32'h100, 0, 5'd8, 1'b1, 0, 1, 0);

        // ALU op write-back, then rd=0 suppression
        run_instr(0, 3'd0, 32'h1234, 0, 5'd5, 1'b1, 0, 1, 0);
        chk("alu rd", rd_addr_wb, 5);
        chk("alu data", wb_data_wb, 32'h1234);
        chk("alu en", wb_en_wb, 1);
        run_instr(0, 3'd0, 32'h55, 0, 5'd0, 1'b1, 0, 1, 0);
        chk("rd0 en", wb_en_wb, 0);

        // reset while waiting for load data; late rvalid must not write back
        chk_en = 1'b0;
        alu_out_mem = 32'h100; rd_addr_mem = 5'd3; wb_en_mem = 1; mem_rd_mem = 1; funct3_mem = 3'd2;
        dmem_gnt = 1;
        @(posedge clk); #1;
        dmem_gnt = 0;
        chk("wait_data stall", mem_stall, 1);
        chk("wait_data req", dmem_req, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        set_nop();
        dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("post-rst stall", mem_stall, 0);
        chk("post-rst req", dmem_req, 0);
        @(posedge clk); #1;
        dmem_rvalid = 0;
        chk("post-rst wb_en", wb_en_wb, 0);
        chk("post-rst wb_data", wb_data_wb, 0);
        chk("post-rst rd", rd_addr_wb, 0);
        m_rd = 0; m_en = 0; m_data = 0;
        chk_en = 1'b1;

        // randomized stream
        for (int i = 0; i < 400; i++) begin
            int kind = $urandom_range(0, 2);
            logic [2:0] f = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : lf[$urandom_range(0, 4)];
            logic [31:0] a = 32'h2000 + $urandom_range(0, 255);
            run_instr(kind, f, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
